axis_uart_bridge_tx: RTL and testbench



---
 rtl/axis_uart_bridge_tx.sv | 141 ++++++++++++++
 tb/tb_axis_uart_bridge_tx.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/axis_uart_bridge_tx.sv
// AXI-Stream to UART 8N1 serializer: each accepted N_BYTES word is sent as
// back-to-back frames, byte 0 first, each byte LSB-first.
module axis_uart_bridge_tx #(
   parameter int unsigned UART_SPEED = 115200,
   parameter int unsigned FREQ_HZ    = 100000000,
   parameter int unsigned N_BYTES    = 32
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [N_BYTES*8-1:0]   S_AXIS_TDATA,
   input  logic                   S_AXIS_TVALID,
   output logic                   S_AXIS_TREADY,
   output logic                   UART_TX,
   output logic                   BUSY
);

   localparam int unsigned BIT_PERIOD = FREQ_HZ / UART_SPEED;
   localparam int unsigned CNT_W      = (BIT_PERIOD < 2) ? 1 : $clog2(BIT_PERIOD);
   localparam int unsigned BI_W       = (N_BYTES < 2) ? 1 : $clog2(N_BYTES);
   localparam int unsigned DATA_W     = N_BYTES * 8;

   if (BIT_PERIOD < 2) begin : g_bad_cfg
      $error("axis_uart_bridge_tx: FREQ_HZ/UART_SPEED must be at least 2");
   end

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t              r_state, w_state;
   logic [CNT_W-1:0]    r_cnt, w_cnt;
   logic [2:0]          r_bit_idx, w_bit_idx;
   logic [BI_W-1:0]     r_byte_idx, w_byte_idx;
   logic [DATA_W-1:0]   r_shift, w_shift;
   logic [7:0]          r_byte, w_byte;
   logic                r_tready, w_tready;
   logic                r_busy, w_busy;
   logic                r_tx, w_tx;
   logic                w_cnt_done;

   assign S_AXIS_TREADY = r_tready;
   assign BUSY          = r_busy;
   assign UART_TX       = r_tx;

   // State and output registers; line level lags the state by one cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_bit_idx  <= '0;
         r_byte_idx <= '0;
         r_shift    <= '0;
         r_byte     <= '0;
         r_tready   <= 1'b0;
         r_busy     <= 1'b0;
         r_tx       <= 1'b1;
      end else begin
         r_state    <= w_state;
         r_cnt      <= w_cnt;
         r_bit_idx  <= w_bit_idx;
         r_byte_idx <= w_byte_idx;
         r_shift    <= w_shift;
         r_byte     <= w_byte;
         r_tready   <= w_tready;
         r_busy     <= w_busy;
         r_tx       <= w_tx;
      end
   end

   // Next-state and output decode.
   always_comb begin
      w_state    = r_state;
      w_cnt      = r_cnt;
      w_bit_idx  = r_bit_idx;
      w_byte_idx = r_byte_idx;
      w_shift    = r_shift;
      w_byte     = r_byte;
      w_tready   = r_tready;
      w_busy     = r_busy;
      w_tx       = 1'b1;
      w_cnt_done = (r_cnt == CNT_W'(BIT_PERIOD - 1));

      case (r_state)
         S_IDLE: begin
            w_tready = 1'b1;
            w_busy   = 1'b0;
            w_cnt    = '0;
            if (r_tready && S_AXIS_TVALID) begin
               w_shift    = S_AXIS_TDATA;
               w_byte_idx = '0;
               w_tready   = 1'b0;
               w_busy     = 1'b1;
               w_state    = S_START;
            end
         end
         S_START: begin
            w_tx = 1'b0;
            if (w_cnt_done) begin
               w_cnt     = '0;
               w_byte    = r_shift[7:0];
               w_bit_idx = '0;
               w_state   = S_DATA;
            end else begin
               w_cnt = r_cnt + CNT_W'(1);
            end
         end
         S_DATA: begin
            w_tx = r_byte[r_bit_idx];
            if (w_cnt_done) begin
               w_cnt = '0;
               if (r_bit_idx == 3'd7) begin
                  w_state = S_STOP;
               end else begin
                  w_bit_idx = r_bit_idx + 3'd1;
               end
            end else begin
               w_cnt = r_cnt + CNT_W'(1);
            end
         end
         S_STOP: begin
            w_tx = 1'b1;
            if (w_cnt_done) begin
               w_cnt = '0;
               if (r_byte_idx < BI_W'(N_BYTES - 1)) begin
                  w_byte_idx = r_byte_idx + BI_W'(1);
                  w_shift    = r_shift >> 8;
                  w_state    = S_START;
               end else begin
                  w_tready = 1'b1;
                  w_busy   = 1'b0;
                  w_state  = S_IDLE;
               end
            end else begin
               w_cnt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_axis_uart_bridge_tx.sv
// Directed bench for axis_uart_bridge_tx: cycle-exact line, BUSY and TREADY
// checks against a frame model built from the word handed in.
module tb_axis_uart_bridge_tx;

   localparam int NB    = 2;
   localparam int BP    = 10;
   localparam int W     = NB * 8;
   localparam int FRAME = NB * 10 * BP;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic [W-1:0]  tdata = '0;
   logic          tvalid = 1'b0;
   wire           tready;
   wire           tx;
   wire           busy;

   int n_total = 0;
   int n_bad   = 0;

   axis_uart_bridge_tx #(
      .UART_SPEED (100000),
      .FREQ_HZ    (1000000),
      .N_BYTES    (NB)
   ) u_dut (
      .clk           (clk),
      .resetn        (resetn),
      .S_AXIS_TDATA  (tdata),
      .S_AXIS_TVALID (tvalid),
      .S_AXIS_TREADY (tready),
      .UART_TX       (tx),
      .BUSY          (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Expected line level c cycles after the accepting edge.
   function automatic logic exp_line(input logic [W-1:0] d, input int c);
      int pos, fb, bn;
      if (c == 0 || c > FRAME) return 1'b1;
      pos = (c - 1) / BP;
      fb  = pos % 10;
      bn  = pos / 10;
      if (fb == 0) return 1'b0;
      if (fb == 9) return 1'b1;
      return d[bn*8 + fb - 1];
   endfunction

   // Caller has TVALID/TDATA set; handshake happens on the next edge.
   task automatic xfer(input logic [W-1:0] d, input bit noisy,
                       input bit nxt_valid, input logic [W-1:0] nxt_data);
      logic [W-1:0] rx;
      int pos, fb;
      rx = '0;
      chk("tready_pre", 32'(tready), 32'd1);
      @(posedge clk); #1;
      for (int c = 0; c <= FRAME; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
         end
         chk("tx", 32'(tx), 32'(exp_line(d, c)));
         chk("busy", 32'(busy), 32'(c < FRAME));
         chk("tready", 32'(tready), 32'(c == FRAME));
         if (c > 0) begin
            pos = (c - 1) / BP;
            fb  = pos % 10;
            if ((c - 1) % BP == BP / 2 && fb >= 1 && fb <= 8)
               rx[(pos / 10) * 8 + fb - 1] = tx;
         end
         if (c == FRAME - 1) begin
            tvalid = nxt_valid;
            tdata  = nxt_data;
         end else if (noisy && c < FRAME - 1) begin
            tvalid = 1'($urandom_range(0, 1));
            tdata  = W'($urandom);
         end else if (c < FRAME - 1) begin
            tvalid = 1'b0;
         end
      end
      chk("word", 32'(rx), 32'(d));
   endtask

   initial begin
      // Reset held, then released mid-cycle
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_tready", 32'(tready), 32'd0);
      #2 resetn = 1'b1;
      #1;
      chk("rel_tready_pre_edge", 32'(tready), 32'd0);
      @(posedge clk); #1;
      chk("rel_tready", 32'(tready), 32'd1);
      chk("rel_tx", 32'(tx), 32'd1);
      chk("rel_busy", 32'(busy), 32'd0);

      // Single word
      tdata = 16'h3C81; tvalid = 1'b1;
      xfer(16'h3C81, 1'b0, 1'b0, '0);

      // Back-to-back words with TVALID held
      tdata = 16'hFFFF; tvalid = 1'b1;
      xfer(16'hFFFF, 1'b0, 1'b1, 16'h0000);
      xfer(16'h0000, 1'b0, 1'b0, '0);

      // Noise on TVALID/TDATA while busy
      tdata = 16'h5AC3; tvalid = 1'b1;
      xfer(16'h5AC3, 1'b1, 1'b0, 16'h1234);
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         chk("quiet_tx", 32'(tx), 32'd1);
         chk("quiet_busy", 32'(busy), 32'd0);
      end

      // Reset asserted mid data bit of byte 0
      tdata = 16'h00A5; tvalid = 1'b1;
      @(posedge clk); #1;
      tvalid = 1'b0;
      chk("ab_busy", 32'(busy), 32'd1);
      repeat (45) @(posedge clk);
      #1;
      chk("ab_pre_bit", 32'(tx), 32'd0);
      #2 resetn = 1'b0;
      #1;
      chk("ab_tx", 32'(tx), 32'd1);
      chk("ab_busy_rst", 32'(busy), 32'd0);
      chk("ab_tready_rst", 32'(tready), 32'd0);
      repeat (15) @(posedge clk);
      #3 resetn = 1'b1;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk); #1;
         chk("ab_idle_tx", 32'(tx), 32'd1);
         chk("ab_idle_busy", 32'(busy), 32'd0);
         chk("ab_idle_tready", 32'(tready), 32'd1);
      end
      tdata = 16'hC31E; tvalid = 1'b1;
      xfer(16'hC31E, 1'b0, 1'b0, '0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
